test_status_monitor: RTL and testbench
======================================

Name: test_status_monitor

Overview:
- Synthesizable, parametrised successor to the simulation top-level pass/fail driver.
- Sequences DUT reset release and tracks per-channel success, failure and heartbeat inputs from NUM_CHANNELS harness sources.
- Enforces a cycle-budget timeout and a no-progress (hang) watchdog.
- Produces a sticky registered verdict with a reason code; the verdict can be read by a bench, an FPGA status register or an emulator.

Parameters:
- NUM_CHANNELS, 4, number of independent status channels (1..32).
- CYCLE_W, 64, width of the run-cycle counter and max_cycles.
- HANG_W, 32, width of the quiet-cycle counter and hang_limit.
- RESET_CYCLES, 16, cycles dut_reset is held after reset deasserts or after a restart (>=1).

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous; re-arms the monitor from PASS or FAIL.
- max_cycles  in  CYCLE_W  run-cycle budget; 0 disables the timeout.
- hang_limit  in  HANG_W  allowed quiet cycles; 0 disables the hang check.
- required_mask  in  NUM_CHANNELS  channels whose success is needed for PASS.
- ch_success  in  NUM_CHANNELS  per-channel success pulse or level.
- ch_fail  in  NUM_CHANNELS  per-channel failure pulse or level.
- ch_heartbeat  in  NUM_CHANNELS  per-channel progress pulse.
- dut_reset  out  1  reset to the DUT.
- done  out  1  verdict valid (sticky).
- pass  out  1  verdict is PASS.
- fail  out  1  verdict is FAIL.
- reason  out  3  verdict reason code.
- fail_channel  out  5  lowest failing channel index.
- cycle_count  out  CYCLE_W  RUN cycles elapsed.
- success_seen  out  NUM_CHANNELS  sticky per-channel success flags.

Behaviour:
- Reset (asynchronous): state=HOLD, hold counter=0, dut_reset=1, done=pass=fail=0, reason=NONE(0), fail_channel=0, cycle_count=0, quiet counter=0, success_seen=0.
- All outputs are registered.
- States are HOLD, RUN, PASS and FAIL.
- HOLD:
  - dut_reset=1; the hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD, go to RUN; dut_reset is 0 from the first RUN cycle.
  - ch_* inputs are ignored in HOLD.
  - Entering HOLD clears cycle_count, the quiet counter and success_seen.
- RUN:
  - cycle_count increments by 1 per RUN cycle and saturates at all-ones.
  - success_seen |= ch_success each cycle.
  - Quiet counter: cleared in any cycle where (ch_heartbeat & required_mask) != 0; otherwise increments, saturating.
  - Each RUN cycle evaluates these conditions in priority order:
    - (1) CHFAIL: any ch_fail bit set. Next state FAIL, reason=2, fail_channel=lowest set index.
    - (2) TIMEOUT: max_cycles != 0 and cycle_count >= max_cycles. Next state FAIL, reason=3.
    - (3) HANG: hang_limit != 0 and quiet counter >= hang_limit. Next state FAIL, reason=4.
    - (4) PASS: (success_seen | ch_success) & required_mask == required_mask, and required_mask != 0. Next state PASS, reason=1.
  - The verdict is visible the cycle after the condition holds: done=1, plus pass=1 or fail=1.
  - Simultaneous fail and success in the same cycle gives FAIL (CHFAIL).
  - With required_mask == 0 the block never passes; only failures end the test.
- PASS/FAIL:
  - Sticky; counters are frozen and ch_* inputs are ignored; dut_reset stays 0.
  - restart=1 moves to HOLD: done, pass and fail clear and reason=NONE on the next cycle.
  - restart is ignored in HOLD and RUN.
- Reset asserted mid-RUN returns to the reset state immediately (asynchronous).
- max_cycles, hang_limit and required_mask are sampled live each cycle; the harness must hold them stable during RUN.
- fail_channel is 0 for reasons other than CHFAIL; it is 5 bits wide regardless of NUM_CHANNELS.

Decomposition:
- test_status_pkg holds:
  - state enum: HOLD=0, RUN=1, PASS=2, FAIL=3;
  - reason enum: NONE=0, PASS=1, CHFAIL=2, TIMEOUT=3, HANG=4;
  - a lowest-set-bit index function.
- One sub-module, reset_release_seq: the HOLD counter and dut_reset generation, with a restart input.
- The FSM, counters and verdict logic live in the top module.

Test Plan:
- RESET_CYCLES=16, required_mask=4'b0011; ch_success[0] pulses at RUN cycle 5 and ch_success[1] at cycle 9. Expect dut_reset low at cycle 16 after reset; done=pass=1, reason=1 one cycle after cycle 9; success_seen=4'b0011.
- ch_fail[2] and ch_fail[3] assert together with the final success. Expect fail=1, reason=2, fail_channel=2, pass=0.
- max_cycles=10, no success. Expect fail=1, reason=3 exactly one cycle after cycle_count reaches 10, then cycle_count frozen at 10. Repeat with max_cycles=0 for 1000 cycles: expect no verdict.
- hang_limit=8, a heartbeat every 5 cycles, then heartbeats stop at cycle 40. Expect reason=4 nine cycles after the last heartbeat. A heartbeat only on an unmasked channel must not clear the quiet counter.
- From PASS, pulse restart. Expect done=0 and dut_reset=1 next cycle, success_seen=0, 16 HOLD cycles, then RUN again. restart pulsed during RUN has no effect.
- Assert reset asynchronously mid-RUN, off a clock edge. Expect all outputs at reset values immediately and dut_reset=1.

Source files
------------

// File: rtl/test_status_pkg.sv
// Shared types and helpers for the test status monitor: FSM states, verdict
// reason codes and a lowest-set-bit encoder used to report the failing channel.
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    RSN_NONE    = 3'd0,
    RSN_PASS    = 3'd1,
    RSN_CHFAIL  = 3'd2,
    RSN_TIMEOUT = 3'd3,
    RSN_HANG    = 3'd4
  } reason_e;

  localparam int MAX_CHANNELS = 32;
  localparam int CH_IDX_W     = 5;

  // Scans from the top so the last hit written is the lowest set index.
  function automatic logic [CH_IDX_W-1:0] lowest_set_idx(input logic [MAX_CHANNELS-1:0] vec);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Harness-facing bundle of the status monitor: run configuration, per-channel
// status inputs and the registered verdict outputs.
interface test_status_monitor_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CYCLE_W      = 64,
  parameter int HANG_W       = 32
) ();

  logic                    restart;
  logic [CYCLE_W-1:0]      max_cycles;
  logic [HANG_W-1:0]       hang_limit;
  logic [NUM_CHANNELS-1:0] required_mask;
  logic [NUM_CHANNELS-1:0] ch_success;
  logic [NUM_CHANNELS-1:0] ch_fail;
  logic [NUM_CHANNELS-1:0] ch_heartbeat;

  logic                    dut_reset;
  logic                    done;
  logic                    pass;
  logic                    fail;
  logic [2:0]              reason;
  logic [4:0]              fail_channel;
  logic [CYCLE_W-1:0]      cycle_count;
  logic [NUM_CHANNELS-1:0] success_seen;

  // Harness side: drives configuration and channel status, observes the verdict.
  modport master (
    output restart, max_cycles, hang_limit, required_mask,
    output ch_success, ch_fail, ch_heartbeat,
    input  dut_reset, done, pass, fail, reason, fail_channel,
    input  cycle_count, success_seen
  );

  // Monitor side.
  modport slave (
    input  restart, max_cycles, hang_limit, required_mask,
    input  ch_success, ch_fail, ch_heartbeat,
    output dut_reset, done, pass, fail, reason, fail_channel,
    output cycle_count, success_seen
  );

endinterface

// File: rtl/test_status_monitor_reset_release_seq.sv
// Holds the DUT in reset for RESET_CYCLES cycles after power-on reset or a
// restart request, and flags the last hold cycle so the monitor can enter RUN.
module reset_release_seq #(
  parameter int RESET_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic release_o,
  output logic dut_reset_o
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (restart_i) begin
      hold_d = 1'b1;
      cnt_d  = '0;
    end else if (hold_q) begin
      if (cnt_q == CNT_LAST) hold_d = 1'b0;
      else                   cnt_d  = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign release_o   = hold_q && (cnt_q == CNT_LAST);
  assign dut_reset_o = hold_q;

endmodule

// File: rtl/test_status_monitor.sv
// Synthesizable pass/fail monitor: sequences DUT reset, tracks per-channel
// status, enforces timeout and hang watchdogs and latches a sticky verdict.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CYCLE_W      = 64,
  parameter int HANG_W       = 32,
  parameter int RESET_CYCLES = 16
) (
  input logic                 clock,
  input logic                 reset,
  test_status_monitor_if.slave bus
);

  localparam logic [CYCLE_W-1:0] CYC_ONE  = CYCLE_W'(1);
  localparam logic [HANG_W-1:0]  HANG_ONE = HANG_W'(1);

  state_e                  state_q, state_d;
  reason_e                 reason_q, reason_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic [CH_IDX_W-1:0]     fchan_q, fchan_d;
  logic [CYCLE_W-1:0]      cycle_q, cycle_d;
  logic [HANG_W-1:0]       quiet_q, quiet_d;
  logic [NUM_CHANNELS-1:0] seen_q, seen_d;

  logic                    release_w;
  logic                    restart_w;
  logic                    dut_reset_w;
  logic [NUM_CHANNELS-1:0] seen_next;
  logic [MAX_CHANNELS-1:0] fail_vec;
  logic                    hb_any;

  // Restart only has meaning once a verdict has been latched.
  assign restart_w = bus.restart && ((state_q == ST_PASS) || (state_q == ST_FAIL));

  reset_release_seq #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_reset_release_seq (
    .clk_i       (clock),
    .rst_i       (reset),
    .restart_i   (restart_w),
    .release_o   (release_w),
    .dut_reset_o (dut_reset_w)
  );

  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    fchan_d   = fchan_q;
    cycle_d   = cycle_q;
    quiet_d   = quiet_q;
    seen_d    = seen_q;
    seen_next = seen_q | bus.ch_success;
    hb_any    = |(bus.ch_heartbeat & bus.required_mask);
    fail_vec  = '0;
    fail_vec[NUM_CHANNELS-1:0] = bus.ch_fail;

    case (state_q)
      ST_HOLD: begin
        if (release_w) state_d = ST_RUN;
      end
      ST_RUN: begin
        seen_d = seen_next;
        if (hb_any)        quiet_d = '0;
        else if (!(&quiet_q)) quiet_d = quiet_q + HANG_ONE;
        // Verdict priority: channel failure, timeout, hang, then pass.
        if (|bus.ch_fail) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = RSN_CHFAIL;
          fchan_d  = lowest_set_idx(fail_vec);
        end else if ((bus.max_cycles != '0) && (cycle_q >= bus.max_cycles)) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = RSN_TIMEOUT;
        end else if ((bus.hang_limit != '0) && (quiet_q >= bus.hang_limit)) begin
          state_d  = ST_FAIL;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          reason_d = RSN_HANG;
        end else if ((bus.required_mask != '0) &&
                     ((seen_next & bus.required_mask) == bus.required_mask)) begin
          state_d  = ST_PASS;
          done_d   = 1'b1;
          pass_d   = 1'b1;
          reason_d = RSN_PASS;
        end else if (!(&cycle_q)) begin
          cycle_d = cycle_q + CYC_ONE;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (bus.restart) begin
          state_d  = ST_HOLD;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          reason_d = RSN_NONE;
          fchan_d  = '0;
          cycle_d  = '0;
          quiet_d  = '0;
          seen_d   = '0;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HOLD;
      reason_q <= RSN_NONE;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      fchan_q  <= '0;
      cycle_q  <= '0;
      quiet_q  <= '0;
      seen_q   <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      fchan_q  <= fchan_d;
      cycle_q  <= cycle_d;
      quiet_q  <= quiet_d;
      seen_q   <= seen_d;
    end
  end

  assign bus.dut_reset    = dut_reset_w;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.reason       = reason_q;
  assign bus.fail_channel = fchan_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.success_seen = seen_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: directed scenarios plus randomized runs checked
// against a timestamp-based reference model of the verdict rules.
module tb_test_status_monitor;

  localparam int NCH = 4;
  localparam int CW  = 64;
  localparam int HW  = 32;
  localparam int RC  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  test_status_monitor_if #(.NUM_CHANNELS(NCH), .CYCLE_W(CW), .HANG_W(HW)) bus ();

  test_status_monitor #(
    .NUM_CHANNELS(NCH), .CYCLE_W(CW), .HANG_W(HW), .RESET_CYCLES(RC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0=hold, 1=run, 2=verdict latched.
  int          m_phase;
  int          m_hold;
  longint      m_cyc;
  longint      m_last_hb;
  logic [3:0]  m_seen;
  logic        m_pass, m_fail;
  logic [2:0]  m_reason;
  logic [4:0]  m_fch;

  wire [79:0] obs = {bus.dut_reset, bus.done, bus.pass, bus.fail, bus.reason,
                     bus.fail_channel, bus.cycle_count, bus.success_seen};
  wire [79:0] exp_v = {(m_phase == 0), (m_phase == 2), m_pass, m_fail, m_reason,
                       m_fch, 64'(m_cyc), m_seen};
  localparam logic [79:0] RESET_VEC = {1'b1, 79'b0};

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_cyc = 0; m_last_hb = -1; m_seen = '0;
    m_pass = 1'b0; m_fail = 1'b0; m_reason = 3'd0; m_fch = 5'd0;
  endtask

  task automatic model_verdict(input logic is_pass, input logic [2:0] rsn);
    m_phase = 2; m_pass = is_pass; m_fail = !is_pass; m_reason = rsn;
  endtask

  // One clock of the model, using the inputs present during that cycle.
  task automatic model_clock();
    longint j, quiet;
    case (m_phase)
      0: begin
        m_hold++;
        if (m_hold == RC) m_phase = 1;
      end
      1: begin
        j = m_cyc;
        quiet = j - m_last_hb - 1;
        m_seen = m_seen | bus.ch_success;
        if (bus.ch_fail != 0) begin
          model_verdict(1'b0, 3'd2);
          for (int i = NCH - 1; i >= 0; i--) if (bus.ch_fail[i]) m_fch = 5'(i);
        end else if (bus.max_cycles != 0 && j >= longint'(bus.max_cycles))
          model_verdict(1'b0, 3'd3);
        else if (bus.hang_limit != 0 && quiet >= longint'(bus.hang_limit))
          model_verdict(1'b0, 3'd4);
        else if (bus.required_mask != 0 && (m_seen & bus.required_mask) == bus.required_mask)
          model_verdict(1'b1, 3'd1);
        else
          m_cyc++;
        if ((bus.ch_heartbeat & bus.required_mask) != 0) m_last_hb = j;
      end
      default: if (bus.restart) model_reset();
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic clear_ch();
    bus.ch_success = '0; bus.ch_fail = '0; bus.ch_heartbeat = '0; bus.restart = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic go_run();
    bit ok;
    ok = 0;
    if (m_phase == 2) begin
      bus.restart = 1'b1; tick(); bus.restart = 1'b0;
    end
    for (int i = 0; i < 4 * RC; i++) begin
      if (bus.dut_reset === 1'b0) begin ok = 1; break; end
      tick();
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL go_run: dut_reset=%b, required 0 within %0d cycles", bus.dut_reset, 4 * RC);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (obs !== RESET_VEC) begin
      n_err++; $display("FAIL reset_state: got %h required %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_pass_sequence();
    bus.required_mask = 4'b0011; bus.max_cycles = '0; bus.hang_limit = '0;
    apply_reset();
    for (int k = 1; k <= RC; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL hold_seq k=%0d: got %h required %h", k, obs, exp_v);
      end
      if (k == RC - 1 || k == RC) begin
        n_vec++;
        if (bus.dut_reset !== (k == RC - 1)) begin
          n_err++; $display("FAIL dut_reset_release k=%0d: got %b required %b", k, bus.dut_reset, k == RC - 1);
        end
      end
    end
    for (int i = 0; i < 30; i++) begin
      bus.ch_success = (m_cyc == 5) ? 4'b0001 : (m_cyc == 9) ? 4'b0010 : 4'b0000;
      tick();
      bus.ch_success = '0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL pass_run i=%0d: got %h required %h", i, obs, exp_v);
      end
      if (bus.done === 1'b1) break;
    end
    n_vec++;
    if ({bus.done, bus.pass, bus.fail, bus.reason, bus.success_seen, bus.cycle_count} !==
        {1'b1, 1'b1, 1'b0, 3'd1, 4'b0011, 64'd9}) begin
      n_err++;
      $display("FAIL pass_verdict: done=%b pass=%b fail=%b reason=%0d seen=%b cyc=%0d, required 1 1 0 1 0011 9",
               bus.done, bus.pass, bus.fail, bus.reason, bus.success_seen, bus.cycle_count);
    end
  endtask

  task automatic test_chfail_priority();
    bus.required_mask = 4'b0011;
    go_run();
    for (int i = 0; i < 30; i++) begin
      bus.ch_success = (m_cyc == 2) ? 4'b0001 : (m_cyc == 4) ? 4'b0010 : 4'b0000;
      bus.ch_fail    = (m_cyc == 4) ? 4'b1100 : 4'b0000;
      tick();
      clear_ch();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL chfail_run i=%0d: got %h required %h", i, obs, exp_v);
      end
      if (bus.done === 1'b1) break;
    end
    n_vec++;
    if ({bus.done, bus.pass, bus.fail, bus.reason, bus.fail_channel} !== {1'b1, 1'b0, 1'b1, 3'd2, 5'd2}) begin
      n_err++;
      $display("FAIL chfail_verdict: done=%b pass=%b fail=%b reason=%0d ch=%0d, required 1 0 1 2 2",
               bus.done, bus.pass, bus.fail, bus.reason, bus.fail_channel);
    end
  endtask

  task automatic test_timeout();
    bus.required_mask = 4'b0011; bus.max_cycles = 64'd10; bus.hang_limit = '0;
    go_run();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL timeout_run i=%0d: got %h required %h", i, obs, exp_v);
      end
      if (bus.done === 1'b1) break;
    end
    repeat (5) tick();
    n_vec++;
    if ({bus.done, bus.fail, bus.reason, bus.cycle_count} !== {1'b1, 1'b1, 3'd3, 64'd10}) begin
      n_err++;
      $display("FAIL timeout_verdict: done=%b fail=%b reason=%0d cyc=%0d, required 1 1 3 10",
               bus.done, bus.fail, bus.reason, bus.cycle_count);
    end
  endtask

  task automatic test_no_timeout();
    bit saw_done;
    saw_done = 0;
    bus.required_mask = 4'b0011; bus.max_cycles = '0; bus.hang_limit = '0;
    go_run();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.done !== 1'b0) saw_done = 1;
    end
    n_vec++;
    if (saw_done || bus.cycle_count !== 64'd1000 || obs !== exp_v) begin
      n_err++;
      $display("FAIL no_timeout: saw_done=%b cyc=%0d, required 0 1000 (model %h got %h)",
               saw_done, bus.cycle_count, exp_v, obs);
    end
  endtask

  task automatic test_hang();
    bus.required_mask = 4'b0011; bus.max_cycles = '0; bus.hang_limit = 32'd8;
    apply_reset();
    go_run();
    for (int i = 0; i < 100; i++) begin
      // After the last masked heartbeat only the unmasked channel keeps beating.
      bus.ch_heartbeat = (m_cyc <= 40 && m_cyc % 5 == 0) ? 4'b0001 :
                         (m_cyc > 40) ? 4'b1000 : 4'b0000;
      tick();
      bus.ch_heartbeat = '0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL hang_run i=%0d: got %h required %h", i, obs, exp_v);
      end
      if (bus.done === 1'b1) break;
    end
    n_vec++;
    if ({bus.done, bus.fail, bus.reason, bus.cycle_count} !== {1'b1, 1'b1, 3'd4, 64'd49}) begin
      n_err++;
      $display("FAIL hang_verdict: done=%b fail=%b reason=%0d cyc=%0d, required 1 1 4 49",
               bus.done, bus.fail, bus.reason, bus.cycle_count);
    end
  endtask

  task automatic test_restart();
    bus.required_mask = 4'b0001; bus.max_cycles = '0; bus.hang_limit = '0;
    go_run();
    for (int i = 0; i < 20; i++) begin
      bus.restart    = (m_cyc == 1);
      bus.ch_success = (m_cyc == 3) ? 4'b0001 : 4'b0000;
      tick();
      clear_ch();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL restart_in_run i=%0d: got %h required %h", i, obs, exp_v);
      end
      if (bus.done === 1'b1) break;
    end
    n_vec++;
    if (bus.pass !== 1'b1) begin
      n_err++; $display("FAIL restart_pre_pass: pass=%b required 1", bus.pass);
    end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    n_vec++;
    if ({bus.done, bus.pass, bus.dut_reset, bus.reason, bus.success_seen} !== {1'b0, 1'b0, 1'b1, 3'd0, 4'b0000}) begin
      n_err++;
      $display("FAIL restart_clear: done=%b pass=%b dut_reset=%b reason=%0d seen=%b, required 0 0 1 0 0000",
               bus.done, bus.pass, bus.dut_reset, bus.reason, bus.success_seen);
    end
    for (int k = 1; k <= RC; k++) begin
      // Channel activity and restart in HOLD must be ignored.
      bus.ch_success = 4'($urandom); bus.ch_fail = 4'($urandom); bus.restart = 1'($urandom);
      tick();
      clear_ch();
      n_vec++;
      if (obs !== exp_v || bus.dut_reset !== (k < RC)) begin
        n_err++; $display("FAIL restart_hold k=%0d: got %h required %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      bus.required_mask = 4'($urandom_range(0, 15));
      bus.max_cycles    = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(5, 60));
      bus.hang_limit    = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 12));
      go_run();
      for (int i = 0; i < 120; i++) begin
        bus.ch_success   = 4'($urandom) & 4'($urandom) & 4'($urandom);
        bus.ch_fail      = 4'($urandom) & 4'($urandom) & 4'($urandom) &
                           4'($urandom) & 4'($urandom) & 4'($urandom);
        bus.ch_heartbeat = 4'($urandom);
        bus.restart      = ($urandom_range(0, 9) == 0);
        tick();
        clear_ch();
        n_vec++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL random r=%0d i=%0d: got %h required %h", r, i, obs, exp_v);
        end
        if (m_phase == 2) break;
      end
      for (int i = 0; i < 3; i++) begin
        bus.ch_success = 4'($urandom); bus.ch_fail = 4'($urandom); bus.ch_heartbeat = 4'($urandom);
        tick();
        clear_ch();
        n_vec++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL random_sticky r=%0d i=%0d: got %h required %h", r, i, obs, exp_v);
        end
      end
      if (m_phase != 2) apply_reset();
    end
  endtask

  task automatic test_async_reset();
    bus.required_mask = 4'b0011; bus.max_cycles = '0; bus.hang_limit = '0;
    go_run();
    bus.ch_success = 4'b0001;
    repeat (3) tick();
    clear_ch();
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if (obs !== RESET_VEC) begin
      n_err++; $display("FAIL async_reset: got %h required %h", obs, RESET_VEC);
    end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL post_async_reset k=%0d: got %h required %h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    clear_ch();
    bus.max_cycles = '0; bus.hang_limit = '0; bus.required_mask = '0;
    model_reset();
    test_reset();
    test_pass_sequence();
    test_chfail_priority();
    test_timeout();
    test_no_timeout();
    test_hang();
    test_restart();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
